// File: rtl/frame_line_scheduler.sv
// -----------------------------------------------------------------------------
// frame_line_scheduler
//
// Purpose:
//   Owns the single x/y/char/we write port of a COLS x ROWS character frame
//   buffer. Two character-stream requesters share it (s0: trade/arbitrage log,
//   s1: keyboard/console echo). Every message occupies whole text lines on a
//   circular row pointer; the columns after the last character are padded with
//   blank (0). The scheduler also maintains the line_start/line_end highlight
//   window over the most recent HL_LINES committed lines, and performs a
//   full-screen clear when asked to.
//
// Ports:
//   clk, reset            system clock; asynchronous active-high reset
//   clr                   one-cycle clear-screen request (latched until served)
//   s0_valid/char/last    requester 0 character stream, s0_ready = accept
//   s1_valid/char/last    requester 1 character stream, s1_ready = accept
//   fb_x/fb_y/fb_char     frame buffer write address and data (registered)
//   fb_we                 frame buffer write enable (registered)
//   line_start/line_end   first / most recent row of the highlight window
//   busy                  high in any state other than IDLE
// -----------------------------------------------------------------------------
module frame_line_scheduler #(
    parameter int COLS     = 40,
    parameter int ROWS     = 30,
    parameter int HL_LINES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       s0_valid,
    input  logic [5:0] s0_char,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic       s1_valid,
    input  logic [5:0] s1_char,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic [5:0] fb_x,
    output logic [5:0] fb_y,
    output logic [5:0] fb_char,
    output logic       fb_we,
    output logic [5:0] line_start,
    output logic [5:0] line_end,
    output logic       busy
);

    localparam int               CNT_W    = $clog2(HL_LINES + 1);
    localparam logic [5:0]       COL_LAST = 6'(COLS - 1);
    localparam logic [5:0]       ROW_LAST = 6'(ROWS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HL_LINES);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        PAD,
        COMMIT
    } state_t;

    state_t           state_q;
    logic [5:0]       row_q;
    logic [5:0]       col_q;
    logic [5:0]       cx_q;
    logic [5:0]       cy_q;
    logic             grant_q;
    logic             last_grant_q;
    logic             clr_pending_q;
    logic [CNT_W-1:0] count_q;
    logic             fb_we_q;
    logic [5:0]       fb_x_q;
    logic [5:0]       fb_y_q;
    logic [5:0]       fb_char_q;
    logic [5:0]       line_start_q;
    logic [5:0]       line_end_q;
    logic             s0_ready_q;
    logic             s1_ready_q;
    logic             busy_q;

    // Next-state helpers shared by the FSM.
    logic             grant_d;
    logic             hs;
    logic [5:0]       sel_char;
    logic             sel_last;
    logic [CNT_W-1:0] count_d;
    logic [6:0]       ls_sum;
    logic [5:0]       line_start_d;
    logic [5:0]       row_d;

    always_comb begin
        // NOTE: each signal is assigned a default before any condition, so no
        // path through this block leaves it holding a value (no latch).
        grant_d      = s1_valid;
        hs           = 1'b0;
        sel_char     = grant_q ? s1_char : s0_char;
        sel_last     = grant_q ? s1_last : s0_last;
        count_d      = count_q;
        line_start_d = '0;
        row_d        = '0;

        // Both requesting: round robin away from the last winner.
        if (s0_valid && s1_valid) begin
            grant_d = ~last_grant_q;
        end

        // Ready is registered and only ever high in STREAM for the granted side.
        if (state_q == STREAM) begin
            hs = grant_q ? (s1_valid && s1_ready_q) : (s0_valid && s0_ready_q);
        end

        if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_W'(1);
        end

        // (row - count_new + 1) mod ROWS, biased by +ROWS to stay non-negative;
        // the sum is below 2*ROWS so one conditional subtract suffices.
        ls_sum       = 7'(row_q) + 7'(ROWS + 1) - 7'(count_d);
        line_start_d = (ls_sum >= 7'(ROWS)) ? 6'(ls_sum - 7'(ROWS)) : ls_sum[5:0];

        row_d = (row_q == ROW_LAST) ? 6'd0 : row_q + 6'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            row_q         <= '0;
            col_q         <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            clr_pending_q <= 1'b0;
            count_q       <= '0;
            fb_we_q       <= 1'b0;
            fb_x_q        <= '0;
            fb_y_q        <= '0;
            fb_char_q     <= '0;
            line_start_q  <= '0;
            line_end_q    <= '0;
            s0_ready_q    <= 1'b0;
            s1_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; later assignments in
            // the same cycle override this default without ordering hazards.
            fb_we_q       <= 1'b0;
            clr_pending_q <= clr_pending_q | clr;

            case (state_q)
                IDLE: begin
                    if (clr_pending_q) begin
                        // A clr arriving in this very cycle stays pending.
                        clr_pending_q <= clr;
                        cx_q          <= '0;
                        cy_q          <= '0;
                        busy_q        <= 1'b1;
                        state_q       <= CLEAR;
                    end else if (s0_valid || s1_valid) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        col_q        <= '0;
                        s0_ready_q   <= ~grant_d;
                        s1_ready_q   <= grant_d;
                        busy_q       <= 1'b1;
                        state_q      <= STREAM;
                    end
                end

                CLEAR: begin
                    fb_we_q   <= 1'b1;
                    fb_x_q    <= cx_q;
                    fb_y_q    <= cy_q;
                    fb_char_q <= '0;
                    if (cx_q == COL_LAST) begin
                        cx_q <= '0;
                        if (cy_q == ROW_LAST) begin
                            row_q        <= '0;
                            count_q      <= '0;
                            line_start_q <= '0;
                            line_end_q   <= '0;
                            busy_q       <= 1'b0;
                            state_q      <= IDLE;
                        end else begin
                            cy_q <= cy_q + 6'd1;
                        end
                    end else begin
                        cx_q <= cx_q + 6'd1;
                    end
                end

                STREAM: begin
                    if (hs) begin
                        fb_we_q   <= 1'b1;
                        fb_x_q    <= col_q;
                        fb_y_q    <= row_q;
                        fb_char_q <= sel_char;
                        if (sel_last) begin
                            s0_ready_q <= 1'b0;
                            s1_ready_q <= 1'b0;
                            if (col_q == COL_LAST) begin
                                state_q <= COMMIT;
                            end else begin
                                col_q   <= col_q + 6'd1;
                                state_q <= PAD;
                            end
                        end else if (col_q == COL_LAST) begin
                            // Line overflow: commit this row and keep streaming
                            // the same message onto the next one.
                            line_end_q   <= row_q;
                            count_q      <= count_d;
                            line_start_q <= line_start_d;
                            row_q        <= row_d;
                            col_q        <= '0;
                        end else begin
                            col_q <= col_q + 6'd1;
                        end
                    end
                end

                PAD: begin
                    fb_we_q   <= 1'b1;
                    fb_x_q    <= col_q;
                    fb_y_q    <= row_q;
                    fb_char_q <= '0;
                    if (col_q == COL_LAST) begin
                        state_q <= COMMIT;
                    end else begin
                        col_q <= col_q + 6'd1;
                    end
                end

                COMMIT: begin
                    line_end_q   <= row_q;
                    count_q      <= count_d;
                    line_start_q <= line_start_d;
                    row_q        <= row_d;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign s0_ready   = s0_ready_q;
    assign s1_ready   = s1_ready_q;
    assign fb_we      = fb_we_q;
    assign fb_x       = fb_x_q;
    assign fb_y       = fb_y_q;
    assign fb_char    = fb_char_q;
    assign line_start = line_start_q;
    assign line_end   = line_end_q;
    assign busy       = busy_q;

endmodule
